// File: rtl/turn_sequencer.sv
// Turn sequencer for a two-player grid game: edge-detects move submissions, handshakes with the grid, tracks turns.
// Optional per-turn forfeit timer is built only when TURN_TIMEOUT_EN is defined.
module turn_sequencer #(
   parameter int TIMEOUT_CYCLES = 250_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       check,
   input  logic [3:0] move,
   input  logic       valid,
   input  logic [2:0] outcome,
   output logic [1:0] user,
   output logic [3:0] move_q,
   output logic       wr_en,
   output logic       clear,
   output logic       reject,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [3:0] move_cnt,
   output logic       timeout
);

   typedef enum logic [2:0] {IDLE, CLEAR, TURN, WAIT, EVAL, DONE} state_t;

   state_t     state, state_nxt;
   logic       check_d;
   logic       chk_edge;
   logic       move_ok;
   logic [1:0] user_nxt, winner_nxt;
   logic [3:0] move_q_nxt, move_cnt_nxt;
   logic       wr_en_nxt, reject_nxt;

   assign chk_edge  = check & ~check_d;
   assign move_ok   = (move >= 4'd1) && (move <= 4'd9);
   assign clear     = (state == CLEAR);
   assign game_over = (state == DONE);

`ifdef TURN_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMR_W-1:0] timer;
   logic             tmo_hit;
   logic             timeout_nxt;

   assign tmo_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

   // Timer sits at zero outside TURN, so every entry into TURN starts a fresh turn clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer   <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= timeout_nxt;
         if (state != TURN || tmo_hit)
            timer <= '0;
         else
            timer <= timer + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         check_d  <= 1'b0;
         user     <= 2'b00;
         move_q   <= 4'd0;
         move_cnt <= 4'd0;
         winner   <= 2'b00;
         wr_en    <= 1'b0;
         reject   <= 1'b0;
      end else begin
         state    <= state_nxt;
         check_d  <= check;
         user     <= user_nxt;
         move_q   <= move_q_nxt;
         move_cnt <= move_cnt_nxt;
         winner   <= winner_nxt;
         wr_en    <= wr_en_nxt;
         reject   <= reject_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      user_nxt     = user;
      move_q_nxt   = move_q;
      move_cnt_nxt = move_cnt;
      winner_nxt   = winner;
      wr_en_nxt    = 1'b0;
      reject_nxt   = 1'b0;
`ifdef TURN_TIMEOUT_EN
      timeout_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) state_nxt = CLEAR;
         end
         CLEAR: begin
            move_cnt_nxt = 4'd0;
            winner_nxt   = 2'b00;
            user_nxt     = 2'b01;
            state_nxt    = TURN;
         end
         TURN: begin
            if (start) begin
               state_nxt = CLEAR;
            end else if (chk_edge) begin
               if (move_ok) begin
                  move_q_nxt = move;
                  wr_en_nxt  = 1'b1;
                  state_nxt  = WAIT;
               end else begin
                  reject_nxt = 1'b1;
               end
`ifdef TURN_TIMEOUT_EN
            end else if (tmo_hit) begin
               timeout_nxt = 1'b1;
               user_nxt    = user ^ 2'b11;
`endif
            end
         end
         // First WAIT cycle carries the wr_en pulse; the grid answers on the second.
         WAIT: begin
            if (start) begin
               state_nxt = CLEAR;
            end else if (!wr_en) begin
               if (valid) begin
                  move_cnt_nxt = (move_cnt == 4'd9) ? 4'd9 : move_cnt + 4'd1;
                  state_nxt    = EVAL;
               end else begin
                  reject_nxt = 1'b1;
                  state_nxt  = TURN;
               end
            end
         end
         EVAL: begin
            if (start) begin
               state_nxt = CLEAR;
            end else if (outcome != 3'd0) begin
               winner_nxt = outcome[1:0];
               state_nxt  = DONE;
            end else if (move_cnt == 4'd9) begin
               winner_nxt = 2'b11;
               state_nxt  = DONE;
            end else begin
               user_nxt  = user ^ 2'b11;
               state_nxt = TURN;
            end
         end
         DONE: begin
            if (start) state_nxt = CLEAR;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
